oam_dma_controller: RTL

OAM_DMA_CONTROLLER -- requirements
Module: oam_dma_controller

---
 rtl/oam_dma_if.sv | 27 ++
 rtl/oam_dma_controller.sv | 97 +++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// OAM DMA bus bundle: CPU-side request signals, memory-map read data,
// and the controller's bus/OAM outputs.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [7:0]  cpu_data_in;
    logic [7:0]  dma_rd_data;
    logic [15:0] bus_addr;
    logic        dma_active;
    logic        cpu_block;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        oam_wren;
    logic [7:0]  dma_reg_out;

    // System side: drives CPU requests and memory read data.
    modport master (
        output cpu_addr, cpu_wren, cpu_data_in, dma_rd_data,
        input  bus_addr, dma_active, cpu_block, oam_addr, oam_data, oam_wren, dma_reg_out
    );

    // Controller side.
    modport slave (
        input  cpu_addr, cpu_wren, cpu_data_in, dma_rd_data,
        output bus_addr, dma_active, cpu_block, oam_addr, oam_data, oam_wren, dma_reg_out
    );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA controller: a CPU write to the DMA register copies DMA_LEN bytes
// from page {src,00} into OAM, one byte per cycle, while blocking non-HRAM
// CPU accesses.
// Optional feature macro: OAM_DMA_ECHO_FOLD_EN folds source pages E0-FF
// down by 8'h20 (echo RAM onto work RAM).
module oam_dma_controller #(
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic     clock,
    input  logic     reset,
    oam_dma_if.slave bus
);

    localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DRAIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_hi_q;
    logic [7:0] src_eff;
    logic       dma_active_q;
    logic       oam_wren_q;
    logic [7:0] oam_addr_q;
    logic       hram_c;
    logic       start_c;

    // Effective source page (optional echo-RAM fold).
`ifdef OAM_DMA_ECHO_FOLD_EN
    assign src_eff = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;
`else
    assign src_eff = src_hi_q;
`endif

    // CPU arbitration: HRAM stays reachable while the transfer owns the bus.
    assign hram_c        = (bus.cpu_addr >= HRAM_LO) && (bus.cpu_addr <= HRAM_HI);
    assign bus.cpu_block = dma_active_q && !hram_c;
    assign start_c       = (state_q == IDLE) && bus.cpu_wren && !bus.cpu_block
                           && (bus.cpu_addr == DMA_REG_ADDR);

    // Next-state and index logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:  if (start_c) state_d = SETUP;
            SETUP: begin
                idx_d   = 8'd0;
                state_d = XFER;
            end
            XFER: begin
                if (idx_q == LAST_IDX) state_d = DRAIN;
                else                   idx_d   = idx_q + 8'd1;
            end
            DRAIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, index and source register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 8'd0;
            src_hi_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (start_c) src_hi_q <= bus.cpu_data_in;
        end
    end

    // Registered status and OAM write strobe/address (one cycle behind XFER).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dma_active_q <= 1'b0;
            oam_wren_q   <= 1'b0;
            oam_addr_q   <= 8'd0;
        end else begin
            dma_active_q <= (state_d != IDLE);
            oam_wren_q   <= (state_q == XFER);
            if (state_q == XFER) oam_addr_q <= idx_q;
        end
    end

    assign bus.bus_addr    = (state_q == XFER) ? {src_eff, idx_q} : bus.cpu_addr;
    assign bus.dma_active  = dma_active_q;
    assign bus.oam_wren    = oam_wren_q;
    assign bus.oam_addr    = oam_addr_q;
    // Synchronous RAM data arrives in the write cycle, so it passes straight through.
    assign bus.oam_data    = oam_wren_q ? bus.dma_rd_data : 8'h00;
    assign bus.dma_reg_out = src_hi_q;

endmodule
